instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Fetch sequencer that sits directly upstream of the instruction shift register. It sends the 16-bit PC to external memory as two bytes, then collects the instruction bytes. It collects 2 bytes for short opcodes and 4 bytes for M_TYPE/I_TYPE. It then replays the buffered bytes to the shift register as an unbroken burst: data_ready is held high for exactly N consecutive cycles. This is required because the shift register clears its byte count whenever data_ready drops.

Parameters:
TIMEOUT_CYCLES, 255, max cycles RECV waits for a memory byte (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
fetch_start  input  1  request a fetch at pc; sampled only in IDLE
pc  input  16  fetch address; latched on accepted fetch_start
busy  output  1  high in every state except IDLE
fetch_done  output  1  one-cycle pulse after the burst completes
mem_out  output  8  address byte to memory
mem_out_valid  output  1  mem_out is valid
mem_out_ready  input  1  memory accepts mem_out this cycle
mem_in  input  8  instruction byte from memory
mem_in_valid  input  1  mem_in is valid this cycle (one byte per high cycle)
data_ready  output  1  to shift register: serial_out carries a byte this cycle
serial_out  output  8  byte to shift register
instr_len  output  3  byte count of current instruction (2 or 4); 0 in IDLE
error  output  1  sticky timeout flag (FETCH_TIMEOUT_EN only); tied 0 otherwise

Behaviour:
- Reset: state=IDLE. All outputs 0, including serial_out, instr_len and error. Byte buffer, index and PC latch cleared. Reset mid-operation aborts immediately; no fetch_done is produced.
- Accepted transfer on the address side = mem_out_valid & mem_out_ready in the same cycle. Receive side has no backpressure: each cycle with mem_in_valid=1 in RECV delivers one byte.
- IDLE:
  - fetch_start=1 latches pc, clears index and goes to SEND_LO next cycle.
  - fetch_start outside IDLE is ignored.
- SEND_LO:
  - mem_out=pc[7:0], mem_out_valid=1.
  - On accept, go to SEND_HI. Otherwise hold; the value must stay stable while not accepted.
- SEND_HI:
  - mem_out=pc[15:8], mem_out_valid=1.
  - On accept, go to RECV with index=0.
  - mem_out_valid=0 in all other states.
- RECV:
  - On mem_in_valid, store mem_in into buf[index] and increment index.
  - When byte 0 is stored, instr_len is set from mem_in[2:0]: 4 if the opcode is M_TYPE or I_TYPE (shared opcode_t encoding), else 2. instr_len holds until return to IDLE.
  - When index reaches instr_len, go to STREAM with index=0.
  - Extra mem_in_valid pulses after the last byte are ignored.
- STREAM:
  - data_ready=1 and serial_out=buf[index] each cycle; index increments.
  - Exactly instr_len consecutive high cycles with no gaps; bytes go out in arrival order (byte0 first).
  - After the last byte, go to DONE.
- DONE:
  - data_ready=0, fetch_done=1 for one cycle, then IDLE.
  - This guarantees at least 2 low cycles of data_ready between bursts, so the shift register count restarts at 0.
- serial_out is 0 whenever data_ready=0.
- SYS_END and unknown opcodes are treated as 2-byte instructions. Halting is the downstream block's responsibility.
- Minimum fetch latency with mem_out_ready tied 1 and immediate bytes:
  - fetch_start at cycle 0.
  - SEND_LO at cycle 1, SEND_HI at cycle 2.
  - RECV from cycle 3.
  - First data_ready one cycle after the last byte is received.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter runs in RECV and resets on every mem_in_valid.
  - If it reaches TIMEOUT_CYCLES with no byte, error is set, state returns to IDLE and no burst or fetch_done is issued.
  - error stays set until rst.
  - fetch_start is accepted again in IDLE while error is set.
- Undefined: no counter; RECV waits indefinitely; error is constant 0.

Test Plan:
- Reset mid-fetch: assert rst during RECV after 1 byte, then fetch pc=0x0010 with a short opcode -> all outputs 0 after rst, no stale byte in the new burst, exactly 2 data_ready cycles.
- R_TYPE fetch: pc=0x1234, mem_out_ready=1 -> mem_out 0x34 then 0x12; bytes 0x40,0xA8 -> instr_len=2, serial_out 0x40,0xA8 on 2 consecutive data_ready cycles, fetch_done one cycle later.
- I_TYPE fetch: byte0 with I_TYPE opcode, then 0x05,0xEF,0xBE -> instr_len=4, 4-cycle gapless burst in order, shift register shows imm=0xBEEF.
- Backpressure: mem_out_ready low 3 cycles in SEND_LO -> mem_out holds 0x34 with valid high; advances only on accept; no duplicate byte.
- Gapped memory: mem_in_valid pulses 5 cycles apart, M_TYPE instruction -> burst is still 4 consecutive cycles; fetch_start pulsed during the burst is ignored.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8: only 1 byte delivered -> error=1 after 8 idle cycles, IDLE, no data_ready. Then a new fetch completes normally with error still 1.

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
// Memory-address / instruction-byte / shift-register bus of the fetch sequencer.
// The master side is the fetch controller; the slave side is memory plus the shift register.
interface instr_fetch_ctrl_if;
    logic [7:0] mem_out;
    logic       mem_out_valid;
    logic       mem_out_ready;
    logic [7:0] mem_in;
    logic       mem_in_valid;
    logic       data_ready;
    logic [7:0] serial_out;

    modport master (
        output mem_out, mem_out_valid, data_ready, serial_out,
        input  mem_out_ready, mem_in, mem_in_valid
    );

    modport slave (
        input  mem_out, mem_out_valid, data_ready, serial_out,
        output mem_out_ready, mem_in, mem_in_valid
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: sends the PC as two address bytes, collects 2 or 4 instruction bytes,
// then replays them as one gapless data_ready burst. Optional RECV timeout: FETCH_TIMEOUT_EN.
module instr_fetch_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_start,
    input  logic [15:0]                pc,
    output logic                       busy,
    output logic                       fetch_done,
    output logic [2:0]                 instr_len,
    output logic                       error,
    instr_fetch_ctrl_if.master         bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND_LO = 3'd1;
    localparam logic [2:0] S_SEND_HI = 3'd2;
    localparam logic [2:0] S_RECV    = 3'd3;
    localparam logic [2:0] S_STREAM  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [2:0] OP_I_TYPE = 3'd1;
    localparam logic [2:0] OP_M_TYPE = 3'd2;

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  buf_q [4];
    logic [7:0]  buf_d [4];
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  len_eff;
    logic        addr_acc;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    assign addr_acc = bus.mem_out_valid & bus.mem_out_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        len_d   = len_q;
        len_eff = len_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fetch_start) begin
                    pc_d    = pc;
                    idx_d   = 2'd0;
                    state_d = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (addr_acc) state_d = S_SEND_HI;
            end
            S_SEND_HI: begin
                if (addr_acc) begin
                    idx_d   = 2'd0;
                    state_d = S_RECV;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_RECV: begin
                if (bus.mem_in_valid) begin
                    buf_d[idx_q] = bus.mem_in;
                    // Length is decided by the opcode in the very first byte.
                    if (idx_q == 2'd0) begin
                        len_d = (bus.mem_in[2:0] == OP_I_TYPE || bus.mem_in[2:0] == OP_M_TYPE)
                                ? 3'd4 : 3'd2;
                    end
                    len_eff = (idx_q == 2'd0) ? len_d : len_q;
                    if ({1'b0, idx_q} + 3'd1 == len_eff) begin
                        idx_d   = 2'd0;
                        state_d = S_STREAM;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    idx_d   = 2'd0;
                    len_d   = 3'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            S_STREAM: begin
                if ({1'b0, idx_q} + 3'd1 == len_q) begin
                    idx_d   = 2'd0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            S_DONE: begin
                len_d   = 3'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // All outputs decode from state so reset forces every one of them to 0.
    assign busy              = (state_q != S_IDLE);
    assign fetch_done        = (state_q == S_DONE);
    assign instr_len         = len_q;
    assign bus.mem_out_valid = (state_q == S_SEND_LO) || (state_q == S_SEND_HI);
    assign bus.mem_out       = (state_q == S_SEND_LO) ? pc_q[7:0]  :
                               (state_q == S_SEND_HI) ? pc_q[15:8] : 8'h00;
    assign bus.data_ready    = (state_q == S_STREAM);
    assign bus.serial_out    = (state_q == S_STREAM) ? buf_q[idx_q] : 8'h00;

`ifdef FETCH_TIMEOUT_EN
    assign error = err_q;
`else
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed fetches push expected address/burst bytes,
// a negedge monitor pops and compares. Timeout cases build only with FETCH_TIMEOUT_EN.
module tb_instr_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_start = 1'b0;
    logic [15:0] pc = '0;
    logic        busy, fetch_done, error;
    logic [2:0]  instr_len;

    instr_fetch_ctrl_if bus ();

    instr_fetch_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_start(fetch_start),
        .pc         (pc),
        .busy       (busy),
        .fetch_done (fetch_done),
        .instr_len  (instr_len),
        .error      (error),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [7:0] exp_addr [$];
    logic [7:0] exp_ser  [$];
    int         exp_len  [$];
    int         run_len = 0;
    logic [7:0] burst [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        fails++;
        $display("FAIL %s: got 0x%0h with nothing expected at %0t", name, act, $time);
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
        end else begin
            if (bus.mem_out_valid) begin
                if (exp_addr.size() == 0) unexpected("mem_out", {24'h0, bus.mem_out});
                else begin
                    check("mem_out", {24'h0, bus.mem_out}, {24'h0, exp_addr[0]});
                    if (bus.mem_out_ready) void'(exp_addr.pop_front());
                end
            end
            if (bus.data_ready) begin
                if (exp_ser.size() == 0) unexpected("serial_out", {24'h0, bus.serial_out});
                else check("serial_out", {24'h0, bus.serial_out}, {24'h0, exp_ser.pop_front()});
                if (exp_len.size() != 0) check("instr_len", {29'h0, instr_len}, exp_len[0]);
                burst[run_len[1:0]] = bus.serial_out;
                run_len++;
            end else begin
                if (bus.serial_out !== 8'h00) check("serial_idle", {24'h0, bus.serial_out}, 32'h0);
                if (fetch_done) begin
                    if (exp_len.size() == 0) unexpected("fetch_done", 32'h1);
                    else check("burst_len", run_len, exp_len.pop_front());
                    run_len = 0;
                end else if (run_len != 0) begin
                    unexpected("burst_gap", run_len);
                    run_len = 0;
                end
            end
        end
    end

    task automatic do_fetch(input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int nb,
                            input int len, input int gap, input int bp,
                            input bit expect_burst, input bit wait_done, input bit poke);
        logic [7:0] b [4];
        int k;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        exp_addr.push_back(a[7:0]);
        exp_addr.push_back(a[15:8]);
        if (expect_burst) begin
            for (int i = 0; i < len; i++) exp_ser.push_back(b[i]);
            exp_len.push_back(len);
        end
        fetch_start = 1'b1;
        pc = a;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        bus.mem_out_ready = (bp == 0);
        repeat (bp) @(posedge clk);
        #0;
        if (bp != 0) begin #1; bus.mem_out_ready = 1'b1; end
        k = 0;
        while (bus.mem_out_valid && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        check("addr_cycles", k, (bp == 0) ? 2 : 2);
        for (int i = 0; i < nb; i++) begin
            repeat (gap) @(posedge clk);
            if (gap != 0) #1;
            bus.mem_in_valid = 1'b1;
            bus.mem_in = b[i];
            @(posedge clk); #1;
            bus.mem_in_valid = 1'b0;
            bus.mem_in = 8'h00;
        end
        if (poke) begin
            fetch_start = 1'b1;
            pc = 16'hDEAD;
            bus.mem_in_valid = 1'b1;
            bus.mem_in = 8'hEE;
            repeat (2) @(posedge clk);
            #1;
            fetch_start = 1'b0;
            bus.mem_in_valid = 1'b0;
        end
        if (wait_done) begin
            k = 0;
            while (busy && k < 60) begin
                @(posedge clk); #1;
                k++;
            end
            check("fetch_finishes", {31'h0, busy}, 32'h0);
        end
    endtask

    initial begin
        int k;
        bus.mem_out_ready = 1'b1;
        bus.mem_in = 8'h00;
        bus.mem_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_instr_len", {29'h0, instr_len}, 32'h0);
        check("rst_serial", {24'h0, bus.serial_out}, 32'h0);
        check("rst_mem_out_valid", {31'h0, bus.mem_out_valid}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // R_TYPE: 0x40 -> 2 bytes.
        do_fetch(16'h1234, 8'h40, 8'hA8, 8'h00, 8'h00, 2, 2, 0, 0, 1, 1, 0);

        // I_TYPE: 0x21 -> 4 bytes, imm from bytes 2/3.
        do_fetch(16'h8000, 8'h21, 8'h05, 8'hEF, 8'hBE, 4, 4, 0, 0, 1, 1, 0);
        check("imm", {16'h0, burst[3], burst[2]}, 32'h0000BEEF);

        // Address backpressure for 3 cycles in SEND_LO.
        do_fetch(16'h1234, 8'h40, 8'hA8, 8'h00, 8'h00, 2, 2, 0, 3, 1, 1, 0);

        // M_TYPE with gapped bytes, plus fetch_start/mem_in pulses during the burst.
        do_fetch(16'hABCD, 8'h12, 8'h11, 8'h22, 8'h33, 4, 4, 5, 0, 1, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        check("start_ignored", {31'h0, busy}, 32'h0);

        // SYS_END opcode is a 2-byte instruction.
        do_fetch(16'h0F0F, 8'h07, 8'h5A, 8'h00, 8'h00, 2, 2, 0, 0, 1, 1, 0);

        // Reset mid-RECV after one byte, then a clean short fetch.
        do_fetch(16'h5555, 8'h21, 8'h00, 8'h00, 8'h00, 1, 4, 0, 0, 0, 0, 0);
        check("abort_in_recv", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_instr_len", {29'h0, instr_len}, 32'h0);
        check("abort_done", {31'h0, fetch_done}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        do_fetch(16'h0010, 8'h08, 8'h99, 8'h00, 8'h00, 2, 2, 0, 0, 1, 1, 0);

`ifdef FETCH_TIMEOUT_EN
        do_fetch(16'h4444, 8'h21, 8'h00, 8'h00, 8'h00, 1, 4, 0, 0, 0, 0, 0);
        k = 0;
        while (busy && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        check("timeout_cycles", k, 8);
        check("timeout_error", {31'h0, error}, 32'h1);
        check("timeout_len", {29'h0, instr_len}, 32'h0);
        do_fetch(16'h0102, 8'h40, 8'h77, 8'h00, 8'h00, 2, 2, 0, 0, 1, 1, 0);
        check("error_sticky", {31'h0, error}, 32'h1);
`else
        check("error_tied", {31'h0, error}, 32'h0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("addr_queue_empty", exp_addr.size(), 0);
        check("ser_queue_empty", exp_ser.size(), 0);
        check("len_queue_empty", exp_len.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end
endmodule
